pixel_frame_tx: RTL
===================

// Module: pixel_frame_tx
// PURPOSE
//  Frame-level pixel transmitter: drives the valid-only pixel stream (start_i/valid/red/green/blue) consumed by
//  median_filter. Takes pixels from an upstream ready/valid source, frames exactly IMAGE_LEN*IMAGE_HEIGHT of them.
//  Emits a one-cycle frame-start pulse and optional per-line blanking gaps, then signals done. Used as the stimulus
//  front-end for filter blocks and as the source half of the on-chip pixel pipeline.
// PARAMETERS
//  IMAGE_LEN      1080  pixels per line (>=2)
//  IMAGE_HEIGHT   720   lines per frame (>=2)
//  HBLANK_CYCLES  0     idle cycles inserted after each line except the last (0 = none)
//  UNDERRUN_LIMIT 16    consecutive starved STREAM cycles before underrun flags (used only with PIXEL_TX_UNDERRUN_EN)
// PORTS
//  clk           in   1  clock
//  rst           in   1  asynchronous reset, active-high
//  start_i       in   1  begin one frame; sampled only in IDLE
//  src_valid_i   in   1  upstream pixel valid
//  src_ready_o   out  1  upstream ready; transfer when src_valid_i && src_ready_o
//  src_red_i     in   8  upstream red
//  src_green_i   in   8  upstream green
//  src_blue_i    in   8  upstream blue
//  frame_start_o out  1  one-cycle pulse; drives downstream start_i
//  valid_o       out  1  downstream pixel valid (no backpressure)
//  red_o         out  8  downstream red
//  green_o       out  8  downstream green
//  blue_o        out  8  downstream blue
//  busy_o        out  1  high in any state except IDLE
//  done_o        out  1  one-cycle pulse, frame complete
//  underrun_o    out  1  sticky starvation flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output 0; state IDLE; col/row counters 0. Async assert aborts any frame immediately.
//  FSM: IDLE -start_i-> SOF -> STREAM; STREAM -line end, not last, HBLANK>0-> BLANK; BLANK -HBLANK_CYCLES elapsed->
//   STREAM; STREAM -last pixel accepted-> DONE; DONE -> IDLE.
//  SOF: frame_start_o=1 for exactly that cycle; src_ready_o=0. Counters cleared.
//  STREAM: src_ready_o=1 (combinational from state). Accepted pixel is registered; valid_o+RGB appear next cycle.
//   Latency 1. Cycles without accept give valid_o=0; RGB holds last value.
//  col counts 0..IMAGE_LEN-1, wraps to 0 with row+1; row counts 0..IMAGE_HEIGHT-1. Widths $clog2 of each dim.
//  Accept at col=IMAGE_LEN-1, row=IMAGE_HEIGHT-1 is the last pixel; src_ready_o drops the following cycle.
//  BLANK, SOF, DONE, IDLE: src_ready_o=0. Upstream held off; no pixel dropped or duplicated.
//  done_o: last pixel accepted cycle N, its valid_o at N+1, done_o at N+1 (DONE state, registered output).
//  start_i outside IDLE ignored, including the DONE cycle. No queuing.
//  Pixel order and values pass through unmodified. Exactly IMAGE_LEN*IMAGE_HEIGHT valid_o pulses per frame.
// CONFIGURATION
//  PIXEL_TX_UNDERRUN_EN defined: counter of consecutive STREAM cycles with src_valid_i=0, cleared on any accept.
//   Reaching UNDERRUN_LIMIT sets underrun_o. Stays 1 until next SOF; frame continues normally.
//  Not defined: counter absent, underrun_o tied 0.
// TESTING (IMAGE_LEN=4, IMAGE_HEIGHT=3, HBLANK_CYCLES=2, UNDERRUN_LIMIT=4)
//  Async reset mid-cycle -> all outputs 0 immediately, busy_o=0.
//  start_i 1 cycle, src_valid_i always 1, pixels 0..11 -> frame_start_o 1 cycle then 12 valid_o in 3 bursts of 4,
//   2 idle cycles between bursts, values 0..11 in order; done_o once with pixel 11; busy_o back to 0.
//  src_valid_i low 3 cycles after pixel 5 -> valid_o gap of 3; pixel 6 follows intact; total still 12.
//  start_i pulsed during STREAM and on DONE cycle -> ignored, single frame; start_i in IDLE later -> new frame.
//  rst pulse after pixel 5 accepted, then start_i -> fresh frame_start_o, 12 pixels from col 0/row 0.
//  With PIXEL_TX_UNDERRUN_EN: stall src 4 cycles mid-row -> underrun_o=1 to end of frame, 0 after next SOF;
//   stall 3 cycles -> stays 0.

Source files
------------

// File: rtl/pixel_frame_tx.sv
// Frame-level pixel transmitter: frames IMAGE_LEN*IMAGE_HEIGHT upstream pixels into a valid-only stream.
// Optional starvation detector enabled by defining PIXEL_TX_UNDERRUN_EN.
module pixel_frame_tx #(
  parameter int IMAGE_LEN      = 1080,
  parameter int IMAGE_HEIGHT   = 720,
  parameter int HBLANK_CYCLES  = 0,
  parameter int UNDERRUN_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       src_valid_i,
  output logic       src_ready_o,
  input  logic [7:0] src_red_i,
  input  logic [7:0] src_green_i,
  input  logic [7:0] src_blue_i,
  output logic       frame_start_o,
  output logic       valid_o,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o
);

  localparam int CW = $clog2(IMAGE_LEN);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int BW = $clog2(HBLANK_CYCLES + 2);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_LEN - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((HBLANK_CYCLES > 0) ? (HBLANK_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOF    = 3'd1,
    S_STREAM = 3'd2,
    S_BLANK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic            valid_q, valid_d;
  logic [23:0]     pix_q, pix_d;
  logic            accept;

  assign src_ready_o = (state_q == S_STREAM);
  assign accept      = src_valid_i & src_ready_o;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blank_d = blank_q;
    valid_d = 1'b0;
    pix_d   = pix_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_SOF;
      end
      S_SOF: begin
        col_d   = '0;
        row_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          valid_d = 1'b1;
          pix_d   = {src_red_i, src_green_i, src_blue_i};
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + RW'(1);
              // No blanking after the final line; done follows directly.
              if (HBLANK_CYCLES > 0) begin
                state_d = S_BLANK;
                blank_d = '0;
              end
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_BLANK: begin
        if (blank_q == BLANK_LAST) state_d = S_STREAM;
        else                       blank_d = blank_q + BW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      blank_q <= '0;
      valid_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
      pix_q   <= pix_d;
    end
  end

  assign frame_start_o = (state_q == S_SOF);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign valid_o       = valid_q;
  assign red_o         = pix_q[23:16];
  assign green_o       = pix_q[15:8];
  assign blue_o        = pix_q[7:0];

`ifdef PIXEL_TX_UNDERRUN_EN
  localparam int UW = $clog2(UNDERRUN_LIMIT + 1);
  localparam logic [UW-1:0] STARVE_LIMIT = UW'(UNDERRUN_LIMIT);

  logic [UW-1:0] starve_q, starve_d;
  logic          underrun_q, underrun_d;

  // Starvation run only advances in STREAM; blanking cycles hold it.
  always_comb begin
    starve_d   = starve_q;
    underrun_d = underrun_q;
    if (state_q == S_SOF) begin
      starve_d   = '0;
      underrun_d = 1'b0;
    end else if (state_q == S_STREAM) begin
      if (accept) begin
        starve_d = '0;
      end else begin
        if (starve_q != STARVE_LIMIT) starve_d = starve_q + UW'(1);
        if (starve_d == STARVE_LIMIT) underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      underrun_q <= underrun_d;
    end
  end

  assign underrun_o = underrun_q;
`else
  assign underrun_o = 1'b0;
`endif

endmodule
